pwm_led_bank: RTL and testbench

- Parametrised N-channel PWM LED brightness driver, driven straight from CLOCK_50.
- Generates PWM and pattern-step timing with internal clock-enable prescalers, so no divided clocks are produced.
- Holds a per-channel duty register bank that can rotate (either direction), breathe, hold, or be written directly.
- Drives LEDR/LEDG brightness patterns from the top level; KEY/SW supply reset, pause, mode and direction.

---
 rtl/pwm_led_bank.sv | 169 ++++++++++++++++
 tb/tb_pwm_led_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_led_bank.sv
`default_nettype none
// ==========================================================================
// pwm_led_bank : N-channel PWM LED driver with hold/rotate/breathe patterns
// Rev 1.0
// ==========================================================================
module pwm_led_bank #(
  parameter int N_CH         = 8,
  parameter int PERIOD       = 100,
  parameter int DUTY_W       = 7,
  parameter int PWM_DIV      = 5000,
  parameter int STEP_DIV     = 50000000,
  parameter int BREATHE_STEP = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              i_mode,
  input  logic                    i_dir,
  input  logic                    i_pause,
  input  logic                    i_wr_en,
  input  logic [$clog2(N_CH)-1:0] i_wr_ch,
  input  logic [DUTY_W-1:0]       i_wr_duty,
  output logic [N_CH-1:0]         o_pwm_out,
  output logic                    o_step_pulse
);

  localparam int PWM_PW  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int STEP_PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int LVL_W   = DUTY_W + 1;

  localparam logic [1:0]         MODE_ROTATE  = 2'b01;
  localparam logic [1:0]         MODE_BREATHE = 2'b10;
  localparam logic [PWM_PW-1:0]  PWM_TC       = PWM_PW'(PWM_DIV - 1);
  localparam logic [STEP_PW-1:0] STEP_TC      = STEP_PW'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_TC       = CNT_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0]  DUTY_MAX     = DUTY_W'(PERIOD);
  localparam logic [LVL_W-1:0]   LVL_PERIOD   = LVL_W'(PERIOD);
  localparam logic [LVL_W-1:0]   LVL_STEP     = LVL_W'(BREATHE_STEP);

  logic [PWM_PW-1:0]  r_pwm_div;
  logic [CNT_W-1:0]   r_pwm_cnt;
  logic [STEP_PW-1:0] r_step_div;
  logic               r_step_pulse;
  logic [DUTY_W-1:0]  r_duty [N_CH];
  logic [DUTY_W-1:0]  r_level;
  logic               r_down;
  logic [1:0]         r_mode_q;
  logic [N_CH-1:0]    r_pwm;

  logic               w_pwm_tick;
  logic               w_step_tick;
  logic               w_enter_breathe;
  logic               w_wr_ok;
  logic [DUTY_W-1:0]  w_wr_duty;
  logic [DUTY_W-1:0]  w_rot [N_CH];
  logic [DUTY_W-1:0]  w_eff [N_CH];
  logic [N_CH-1:0]    w_pwm_nxt;
  logic [LVL_W-1:0]   w_level_sum;
  logic [LVL_W-1:0]   w_level_dif;
  logic [DUTY_W-1:0]  w_level_nxt;
  logic               w_down_nxt;

  assign w_pwm_tick      = (r_pwm_div == PWM_TC);
  assign w_step_tick     = !i_pause && (r_step_div == STEP_TC);
  assign w_enter_breathe = (i_mode == MODE_BREATHE) && (r_mode_q != MODE_BREATHE);
  assign w_wr_ok         = i_wr_en && (int'(i_wr_ch) < N_CH);
  assign w_wr_duty       = (i_wr_duty > DUTY_MAX) ? DUTY_MAX : i_wr_duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_div    <= '0;
      r_pwm_cnt    <= '0;
      r_step_div   <= '0;
      r_step_pulse <= 1'b0;
    end else begin
      r_pwm_div <= w_pwm_tick ? '0 : r_pwm_div + 1'b1;
      if (w_pwm_tick) begin
        r_pwm_cnt <= (r_pwm_cnt == CNT_TC) ? '0 : r_pwm_cnt + 1'b1;
      end
      if (!i_pause) begin
        r_step_div <= w_step_tick ? '0 : r_step_div + 1'b1;
      end
      r_step_pulse <= w_step_tick;
    end
  end

  // Rotation is resolved first so a same-cycle write lands at its post-rotation slot.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_rot[i] = r_duty[i];
    end
    if (w_step_tick && (i_mode == MODE_ROTATE)) begin
      for (int i = 0; i < N_CH; i++) begin
        w_rot[i] = i_dir ? r_duty[(i + 1) % N_CH] : r_duty[(i + N_CH - 1) % N_CH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_duty[i] <= DUTY_W'((i * PERIOD) / N_CH);
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        r_duty[i] <= (w_wr_ok && (int'(i_wr_ch) == i)) ? w_wr_duty : w_rot[i];
      end
    end
  end

  always_comb begin
    w_level_sum = {1'b0, r_level} + LVL_STEP;
    w_level_dif = {1'b0, r_level} - LVL_STEP;
    w_level_nxt = r_level;
    w_down_nxt  = r_down;
    if (!r_down) begin
      if (w_level_sum >= LVL_PERIOD) begin
        w_level_nxt = DUTY_MAX;
        w_down_nxt  = 1'b1;
      end else begin
        w_level_nxt = w_level_sum[DUTY_W-1:0];
      end
    end else begin
      if ({1'b0, r_level} <= LVL_STEP) begin
        w_level_nxt = '0;
        w_down_nxt  = 1'b0;
      end else begin
        w_level_nxt = w_level_dif[DUTY_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level  <= '0;
      r_down   <= 1'b0;
      r_mode_q <= 2'b00;
    end else begin
      r_mode_q <= i_mode;
      if (w_enter_breathe) begin
        r_level <= '0;
        r_down  <= 1'b0;
      end else if (w_step_tick && (i_mode == MODE_BREATHE)) begin
        r_level <= w_level_nxt;
        r_down  <= w_down_nxt;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_eff[i]     = (i_mode == MODE_BREATHE) ? r_level : r_duty[i];
      w_pwm_nxt[i] = (LVL_W'(r_pwm_cnt) < LVL_W'(w_eff[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= w_pwm_nxt;
    end
  end

  assign o_pwm_out    = r_pwm;
  assign o_step_pulse = r_step_pulse;

endmodule
`default_nettype wire

// File: tb/tb_pwm_led_bank.sv
`default_nettype none
// ==========================================================================
// tb_pwm_led_bank : directed, table-driven bench for pwm_led_bank
// Rev 1.0
// ==========================================================================
module tb_pwm_led_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       dir, pause, wr_en;
  logic [1:0] wr_ch;
  logic [3:0] wr_duty;
  logic [3:0] pwm;
  logic       step_pulse;

  logic       wr_en_b;
  logic [2:0] wr_ch_b;
  logic [3:0] wr_duty_b;
  logic [4:0] pwm_b;
  logic       step_pulse_b;

  int checks   = 0;
  int failures = 0;
  int meas   [4];
  int meas_b [5];
  int lv     [9] = '{3, 6, 9, 10, 7, 4, 1, 0, 3};

  typedef struct {
    logic [1:0] ch;
    logic [3:0] duty;
    int         e0, e1, e2, e3;
  } wr_vec_t;

  wr_vec_t vecs [5];

  pwm_led_bank #(
    .N_CH(4), .PERIOD(10), .DUTY_W(4), .PWM_DIV(2), .STEP_DIV(4), .BREATHE_STEP(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_mode(mode), .i_dir(dir), .i_pause(pause),
    .i_wr_en(wr_en), .i_wr_ch(wr_ch), .i_wr_duty(wr_duty),
    .o_pwm_out(pwm), .o_step_pulse(step_pulse)
  );

  // Five channels give a 3-bit write index, so out-of-range channels are reachable.
  pwm_led_bank #(
    .N_CH(5), .PERIOD(10), .DUTY_W(4), .PWM_DIV(2), .STEP_DIV(4), .BREATHE_STEP(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .i_mode(2'b00), .i_dir(1'b0), .i_pause(1'b1),
    .i_wr_en(wr_en_b), .i_wr_ch(wr_ch_b), .i_wr_duty(wr_duty_b),
    .o_pwm_out(pwm_b), .o_step_pulse(step_pulse_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // High-cycle count over one full PWM period equals duty * PWM_DIV.
  task automatic measure();
    for (int c = 0; c < 4; c++) meas[c] = 0;
    for (int c = 0; c < 5; c++) meas_b[c] = 0;
    repeat (3) @(negedge clk);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) meas[c] += int'(pwm[c]);
      for (int c = 0; c < 5; c++) meas_b[c] += int'(pwm_b[c]);
    end
  endtask

  task automatic check_duty(input string tag, input int d0, input int d1, input int d2, input int d3);
    int e [4];
    e = '{d0, d1, d2, d3};
    measure();
    for (int c = 0; c < 4; c++) check($sformatf("%s ch%0d", tag, c), meas[c], 2 * e[c]);
  endtask

  task automatic check_duty_b(input string tag, input int d0, input int d1, input int d2,
                              input int d3, input int d4);
    int e [5];
    e = '{d0, d1, d2, d3, d4};
    measure();
    for (int c = 0; c < 5; c++) check($sformatf("%s chB%0d", tag, c), meas_b[c], 2 * e[c]);
  endtask

  task automatic do_steps(input int n, output int lat);
    int seen;
    int cyc;
    @(posedge clk); #1 pause = 1'b0;
    seen = 0;
    cyc  = 0;
    lat  = 0;
    while (seen < n && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (step_pulse) begin
        seen++;
        if (seen == 1) lat = cyc;
      end
    end
    check("step pulses within budget", seen, n);
    @(posedge clk); #1 pause = 1'b1;
  endtask

  task automatic write_b(input logic [2:0] ch, input logic [3:0] d);
    @(posedge clk); #1 wr_en_b = 1'b1; wr_ch_b = ch; wr_duty_b = d;
    @(posedge clk); #1 wr_en_b = 1'b0;
  endtask

  initial begin
    int lat;
    int hi0;
    int tog;
    int sp;
    logic       prev2;
    logic [3:0] prevp;

    vecs[0] = '{ch: 2'd1, duty: 4'd15, e0: 5,  e1: 10, e2: 0, e3: 2};
    vecs[1] = '{ch: 2'd3, duty: 4'd0,  e0: 5,  e1: 10, e2: 0, e3: 0};
    vecs[2] = '{ch: 2'd0, duty: 4'd10, e0: 10, e1: 10, e2: 0, e3: 0};
    vecs[3] = '{ch: 2'd2, duty: 4'd4,  e0: 10, e1: 10, e2: 4, e3: 0};
    vecs[4] = '{ch: 2'd3, duty: 4'd11, e0: 10, e1: 10, e2: 4, e3: 10};

    mode = 2'b00; dir = 1'b0; pause = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_duty = '0;
    wr_en_b = 1'b0; wr_ch_b = '0; wr_duty_b = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset pwm_out", int'(pwm), 0);
    check("reset step_pulse", int'(step_pulse), 0);
    check("reset B step_pulse", int'(step_pulse_b), 0);
    #2 rst_n = 1'b1;

    hi0 = 0; tog = 0; prev2 = pwm[2];
    repeat (40) begin
      @(negedge clk);
      if (pwm[0]) hi0++;
      if (pwm[2] != prev2) tog++;
      prev2 = pwm[2];
    end
    check("hold ch0 never high", hi0, 0);
    check("hold ch2 toggling", int'(tog >= 3), 1);
    check_duty("hold", 0, 2, 5, 7);

    @(posedge clk); #1 pause = 1'b1;
    @(posedge clk); #1 mode = 2'b01; dir = 1'b0;
    do_steps(1, lat);
    check_duty("rot dir0 step1", 7, 0, 2, 5);
    do_steps(3, lat);
    check_duty("rot dir0 step4", 0, 2, 5, 7);
    @(posedge clk); #1 dir = 1'b1;
    do_steps(1, lat);
    check_duty("rot dir1 step1", 2, 5, 7, 0);

    sp = 0; tog = 0; prevp = pwm;
    repeat (20) begin
      @(negedge clk);
      if (step_pulse) sp++;
      if (pwm != prevp) tog++;
      prevp = pwm;
    end
    check("pause no step_pulse", sp, 0);
    check("pause pwm running", int'(tog > 0), 1);
    check_duty("pause held", 2, 5, 7, 0);
    do_steps(1, lat);
    check("resume latency", lat, 4);
    check_duty("resume step", 5, 7, 0, 2);

    @(posedge clk); #1 mode = 2'b10;
    check_duty("breathe entry", 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      do_steps(1, lat);
      check_duty($sformatf("breathe step%0d", k + 1), lv[k], lv[k], lv[k], lv[k]);
    end
    @(posedge clk); #1 mode = 2'b00;
    check_duty("breathe exit restore", 5, 7, 0, 2);
    @(posedge clk); #1 mode = 2'b10;
    check_duty("breathe reentry clear", 0, 0, 0, 0);
    do_steps(1, lat);
    check_duty("breathe reentry up", 3, 3, 3, 3);
    @(posedge clk); #1 mode = 2'b00;

    for (int v = 0; v < 5; v++) begin
      @(posedge clk); #1 wr_en = 1'b1; wr_ch = vecs[v].ch; wr_duty = vecs[v].duty;
      @(posedge clk); #1 wr_en = 1'b0;
      check_duty($sformatf("write vec%0d", v), vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3);
    end

    check_duty_b("B reset ramp", 0, 2, 4, 6, 8);
    write_b(3'd5, 4'd3);
    check_duty_b("B write ch5 ignored", 0, 2, 4, 6, 8);
    write_b(3'd7, 4'd3);
    check_duty_b("B write ch7 ignored", 0, 2, 4, 6, 8);
    write_b(3'd4, 4'd1);
    check_duty_b("B write ch4", 0, 2, 4, 6, 1);

    // Prescaler is held at 1 here, so the tick falls two cycles after pause drops.
    @(posedge clk); #1 mode = 2'b01; dir = 1'b0;
    @(posedge clk); #1 pause = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 wr_en = 1'b1; wr_ch = 2'd2; wr_duty = 4'd9;
    @(posedge clk); #1 wr_en = 1'b0;
    @(negedge clk);
    check("coincident step_pulse", int'(step_pulse), 1);
    @(posedge clk); #1 pause = 1'b1;
    check_duty("write plus rotate", 10, 10, 9, 4);

    @(posedge clk); #1 pause = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("pre-reset pwm active", int'(pwm != 4'd0), 1);
    rst_n = 1'b0;
    #1;
    check("async reset pwm_out", int'(pwm), 0);
    check("async reset step_pulse", int'(step_pulse), 0);
    @(negedge clk);
    mode = 2'b00; pause = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post-reset step_pulse", int'(step_pulse), 0);
    check_duty("post-reset ramp", 0, 2, 5, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
